aes_core_arbiter: RTL and testbench

- Shares the single AES-128 encrypt core between N_REQ CANsec requesters, e.g. ICV/MAC generation and payload keystream.
- Arbitrates round-robin, latches the winner's 128-bit block, pulses the core start, waits for the core's done, and routes the result back to the winning requester.
- Provides a watchdog timeout and a flush input so a frame abort (tx_success or error) frees the core cleanly.

---
 rtl/aes_core_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_aes_core_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter
// ----------------
// Shares one AES-128 encrypt core between N_REQ requesters. A round-robin
// pick chooses the next requester and latches its 128-bit block. The arbiter
// then pulses aes_start, waits for aes_done and returns the result to the
// requester that won. A watchdog and a flush input make sure an aborted frame
// or a stalled core always returns the arbiter to IDLE.
//
// Ports
//   clk          system clock
//   g_rst        synchronous active-high reset
//   req          per-requester request level (held until its gnt)
//   req_data     plaintext blocks, requester i at [128*i+127 : 128*i]
//   gnt          one-cycle one-hot grant pulse
//   rsp_valid    one-cycle one-hot result pulse
//   rsp_data     result block, held until the next result
//   busy         high whenever the arbiter is not IDLE
//   owner        index of the current or last granted requester
//   aes_start    one-cycle start pulse to the core
//   aes_datain   block presented to the core
//   aes_done     core completion pulse
//   aes_dataout  core result, sampled in the aes_done cycle
//   flush        abort the in-flight operation
//   err_timeout  one-cycle pulse on watchdog expiry
module aes_core_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 64,
  parameter int IDW     = 3
) (
  input  logic                 clk,
  input  logic                 g_rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [128*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [127:0]         rsp_data,
  output logic                 busy,
  output logic [IDW-1:0]       owner,
  output logic                 aes_start,
  output logic [127:0]         aes_datain,
  input  logic                 aes_done,
  input  logic [127:0]         aes_dataout,
  input  logic                 flush,
  output logic                 err_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  logic [IDW-1:0]   last;
  logic [7:0]       timer;
  logic [7:0]       timer_next;

  logic [IDW-1:0]   sel;
  logic [IDW-1:0]   sel_hi;
  logic [IDW-1:0]   sel_lo;
  logic             hit_hi;
  logic [127:0]     sel_data;
  logic [N_REQ-1:0] sel_onehot;
  logic [N_REQ-1:0] owner_onehot;

  logic [N_REQ-1:0] gnt_next;
  logic [N_REQ-1:0] rsp_valid_next;
  logic             start_next;
  logic             tout_next;
  logic             load_grant;
  logic             load_rsp;

  // Round-robin pick: the lowest requester above 'last' wins. If there is
  // none, the lowest requester overall wins (wrap). The loop runs downward so
  // that the final assignment in each class is the lowest index.
  always_comb begin
    sel_hi = '0;
    sel_lo = '0;
    hit_hi = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_lo = IDW'(i);
        if (IDW'(i) > last) begin
          sel_hi = IDW'(i);
          hit_hi = 1'b1;
        end
      end
    end
    sel = hit_hi ? sel_hi : sel_lo;
  end

  // Block mux and one-hot decodes use constant loop indices, so the index
  // width never has to match the vector size.
  always_comb begin
    sel_data     = '0;
    sel_onehot   = '0;
    owner_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == sel) begin
        sel_data      = req_data[128*i +: 128];
        sel_onehot[i] = 1'b1;
      end
      if (IDW'(i) == owner) begin
        owner_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state logic and next values of the registered pulses.
  // Flush outranks aes_done, and aes_done outranks the watchdog.
  always_comb begin
    state_next     = state;
    timer_next     = timer;
    gnt_next       = '0;
    rsp_valid_next = '0;
    start_next     = 1'b0;
    tout_next      = 1'b0;
    load_grant     = 1'b0;
    load_rsp       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          gnt_next   = sel_onehot;
          load_grant = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else begin
          start_next = 1'b1;
          timer_next = '0;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else if (aes_done) begin
          rsp_valid_next = owner_onehot;
          load_rsp       = 1'b1;
          state_next     = ST_IDLE;
        end else if (timer == TLAST) begin
          tout_next  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          timer_next = timer + 8'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register, pulse outputs and data registers.
  always_ff @(posedge clk) begin
    if (g_rst) begin
      state       <= ST_IDLE;
      timer       <= '0;
      last        <= IDW'(N_REQ - 1);
      owner       <= '0;
      gnt         <= '0;
      rsp_valid   <= '0;
      aes_start   <= 1'b0;
      err_timeout <= 1'b0;
      rsp_data    <= '0;
      aes_datain  <= '0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      gnt         <= gnt_next;
      rsp_valid   <= rsp_valid_next;
      aes_start   <= start_next;
      err_timeout <= tout_next;
      if (load_grant) begin
        aes_datain <= sel_data;
        owner      <= sel;
        last       <= sel;
      end
      if (load_rsp) begin
        rsp_data <= aes_dataout;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter
// -------------------
// Directed bench for aes_core_arbiter with N_REQ=2 and TIMEOUT=16. Inputs are
// driven and outputs are sampled on the falling clock edge.
module tb_aes_core_arbiter;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B0  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] B1  = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;
  localparam logic [127:0] B2  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
  localparam logic [127:0] B3  = 128'h123456789abcdef0123456789abcdef0;
  localparam logic [127:0] B4  = 128'hfedcba9876543210fedcba9876543210;
  localparam logic [127:0] B5  = 128'h11111111222222223333333344444444;
  localparam logic [127:0] B6  = 128'h55555555666666667777777788888888;
  localparam logic [127:0] CT2 = 128'hcafef00dcafef00dcafef00dcafef00d;

  logic         clk = 1'b0;
  logic         g_rst;
  logic [1:0]   req;
  logic [255:0] req_data;
  logic [1:0]   gnt;
  logic [1:0]   rsp_valid;
  logic [127:0] rsp_data;
  logic         busy;
  logic [2:0]   owner;
  logic         aes_start;
  logic [127:0] aes_datain;
  logic         aes_done;
  logic [127:0] aes_dataout;
  logic         flush;
  logic         err_timeout;

  int checks = 0;
  int errors = 0;

  aes_core_arbiter #(
    .N_REQ(2),
    .TIMEOUT(16),
    .IDW(3)
  ) dut (
    .clk(clk),
    .g_rst(g_rst),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .busy(busy),
    .owner(owner),
    .aes_start(aes_start),
    .aes_datain(aes_datain),
    .aes_done(aes_done),
    .aes_dataout(aes_dataout),
    .flush(flush),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] reqVal, input logic [255:0] dataVal);
    req      = reqVal;
    req_data = dataVal;
  endtask

  // Grant cycle, then the aes_start cycle (first WAIT cycle, timer 0).
  task automatic grantPhase(input string tag, input logic [1:0] expGnt,
                            input logic [127:0] expBlk, input bit dropReq);
    tick();
    checkOutput({tag, " gnt"}, 128'(gnt), 128'(expGnt));
    checkOutput({tag, " datain"}, aes_datain, expBlk);
    checkOutput({tag, " owner"}, 128'(owner), (expGnt == 2'b10) ? 128'd1 : 128'd0);
    checkOutput({tag, " busy"}, 128'(busy), 128'd1);
    checkOutput({tag, " start early"}, 128'(aes_start), 128'd0);
    if (dropReq) req = 2'b00;
    tick();
    checkOutput({tag, " start"}, 128'(aes_start), 128'd1);
    checkOutput({tag, " gnt off"}, 128'(gnt), 128'd0);
  endtask

  // Core answers 'delay' cycles after the aes_start cycle; result checked next cycle.
  task automatic donePhase(input string tag, input int delay,
                           input logic [127:0] result, input logic [1:0] expRsp);
    repeat (delay) tick();
    aes_done    = 1'b1;
    aes_dataout = result;
    tick();
    checkOutput({tag, " rsp_valid"}, 128'(rsp_valid), 128'(expRsp));
    checkOutput({tag, " rsp_data"}, rsp_data, result);
    checkOutput({tag, " no err"}, 128'(err_timeout), 128'd0);
    checkOutput({tag, " idle"}, 128'(busy), 128'd0);
    aes_done    = 1'b0;
    aes_dataout = '0;
  endtask

  initial begin
    g_rst       = 1'b1;
    req         = 2'b00;
    req_data    = '0;
    aes_done    = 1'b0;
    aes_dataout = '0;
    flush       = 1'b0;

    // Reset state
    repeat (2) tick();
    checkOutput("rst gnt", 128'(gnt), 128'd0);
    checkOutput("rst rsp_valid", 128'(rsp_valid), 128'd0);
    checkOutput("rst busy", 128'(busy), 128'd0);
    checkOutput("rst owner", 128'(owner), 128'd0);
    checkOutput("rst start", 128'(aes_start), 128'd0);
    checkOutput("rst err", 128'(err_timeout), 128'd0);
    checkOutput("rst rsp_data", rsp_data, 128'd0);
    checkOutput("rst datain", aes_datain, 128'd0);
    g_rst = 1'b0;

    // Single request from requester 0
    applyStimulus(2'b01, {B1, PT});
    grantPhase("single", 2'b01, PT, 1'b1);
    donePhase("single", 12, CT, 2'b01);
    tick();
    checkOutput("single pulse end", 128'(rsp_valid), 128'd0);
    checkOutput("single hold", rsp_data, CT);

    // Watchdog: core never answers
    applyStimulus(2'b10, {B1, PT});
    grantPhase("tmo", 2'b10, B1, 1'b1);
    for (int i = 1; i < 16; i++) begin
      tick();
      checkOutput($sformatf("tmo early %0d", i), 128'(err_timeout), 128'd0);
    end
    tick();
    checkOutput("tmo err", 128'(err_timeout), 128'd1);
    checkOutput("tmo rsp_valid", 128'(rsp_valid), 128'd0);
    checkOutput("tmo idle", 128'(busy), 128'd0);
    tick();
    checkOutput("tmo pulse end", 128'(err_timeout), 128'd0);

    // Flush in WAIT, late aes_done ignored
    applyStimulus(2'b01, {B1, B0});
    grantPhase("flushW", 2'b01, B0, 1'b1);
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flushW idle", 128'(busy), 128'd0);
    checkOutput("flushW rsp_valid", 128'(rsp_valid), 128'd0);
    repeat (2) tick();
    aes_done    = 1'b1;
    aes_dataout = B2;
    tick();
    aes_done    = 1'b0;
    aes_dataout = '0;
    checkOutput("flushW late done", 128'(rsp_valid), 128'd0);
    checkOutput("flushW rsp_data kept", rsp_data, CT);
    checkOutput("flushW still idle", 128'(busy), 128'd0);

    // Flush in ISSUE suppresses aes_start
    applyStimulus(2'b01, {B1, B3});
    tick();
    checkOutput("flushI gnt", 128'(gnt), 128'd1);
    flush = 1'b1;
    req   = 2'b00;
    tick();
    flush = 1'b0;
    checkOutput("flushI no start", 128'(aes_start), 128'd0);
    checkOutput("flushI idle", 128'(busy), 128'd0);
    tick();
    checkOutput("flushI no start later", 128'(aes_start), 128'd0);

    // aes_done on the last watchdog cycle: done wins
    applyStimulus(2'b10, {B3, B0});
    grantPhase("coll", 2'b10, B3, 1'b1);
    donePhase("coll", 15, CT2, 2'b10);
    tick();
    checkOutput("coll no late err", 128'(err_timeout), 128'd0);

    // Reset in the middle of WAIT
    applyStimulus(2'b01, {B3, B4});
    grantPhase("rstW", 2'b01, B4, 1'b1);
    repeat (3) tick();
    g_rst = 1'b1;
    tick();
    checkOutput("rstW busy", 128'(busy), 128'd0);
    checkOutput("rstW gnt", 128'(gnt), 128'd0);
    checkOutput("rstW rsp_valid", 128'(rsp_valid), 128'd0);
    checkOutput("rstW start", 128'(aes_start), 128'd0);
    checkOutput("rstW err", 128'(err_timeout), 128'd0);
    checkOutput("rstW owner", 128'(owner), 128'd0);
    checkOutput("rstW datain", aes_datain, 128'd0);
    checkOutput("rstW rsp_data", rsp_data, 128'd0);
    g_rst = 1'b0;

    // Contention after reset: requester 0 first, then strict alternation
    applyStimulus(2'b11, {B5, B6});
    grantPhase("cont0", 2'b01, B6, 1'b0);
    donePhase("cont0", 3, B0, 2'b01);
    grantPhase("cont1", 2'b10, B5, 1'b0);
    donePhase("cont1", 4, B1, 2'b10);
    grantPhase("cont2", 2'b01, B6, 1'b0);
    donePhase("cont2", 2, B2, 2'b01);
    grantPhase("cont3", 2'b10, B5, 1'b0);
    req = 2'b00;
    donePhase("cont3", 5, B3, 2'b10);
    tick();
    checkOutput("cont end idle", 128'(busy), 128'd0);
    checkOutput("cont end gnt", 128'(gnt), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
